// File: rtl/intack_master.sv
// CPU-side 8259A interrupt-acknowledge initiator: issues the two INTA pulses,
// captures the vector during pulse 2 and offers it to the core over valid/ack.
module intack_master #(
   parameter int INTA_LOW    = 2,
   parameter int INTA_GAP    = 2,
   parameter int RECOVER_CYC = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_int,
   input  logic       i_if,
   output logic       o_inta,
   input  logic [7:0] i_data_in,
   input  logic       i_iv_ready,
   output logic [7:0] o_vec,
   output logic       o_vec_valid,
   input  logic       i_vec_ack,
   output logic       o_busy,
   output logic       o_timeout_err
);

   localparam int M1 = (INTA_LOW > INTA_GAP) ? INTA_LOW : INTA_GAP;
   localparam int M2 = (M1 > RECOVER_CYC) ? M1 : RECOVER_CYC;
   localparam int M3 = (M2 > 1) ? M2 : 1;
   localparam int CW = $clog2(M3) + 1;
   localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP - 1);
   localparam logic [CW-1:0] REC_LOAD = CW'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

   typedef enum logic [2:0] {IDLE, ACK1, GAP, ACK2, HOLD, RECOVER} state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_nextCnt;
   logic          r_inta;
   logic          w_nextInta;
   logic [7:0]    r_vec;
   logic [7:0]    w_nextVec;
   logic          r_vecValid;
   logic          w_nextValid;
   logic          r_timeout;
   logic          w_nextTimeout;
   logic          r_cap;
   logic          w_nextCap;
   logic          w_cntZero;

   assign w_cntZero = (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_cnt      <= '0;
         r_inta     <= 1'b1;
         r_vec      <= 8'h00;
         r_vecValid <= 1'b0;
         r_timeout  <= 1'b0;
         r_cap      <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_sync1    <= i_int;
         r_sync2    <= r_sync1;
         r_cnt      <= w_nextCnt;
         r_inta     <= w_nextInta;
         r_vec      <= w_nextVec;
         r_vecValid <= w_nextValid;
         r_timeout  <= w_nextTimeout;
         r_cap      <= w_nextCap;
      end
   end

   always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = r_cnt;
      w_nextInta    = r_inta;
      w_nextVec     = r_vec;
      w_nextValid   = r_vecValid;
      w_nextTimeout = 1'b0;
      w_nextCap     = r_cap;
      case (r_state)
         IDLE: begin
            if (r_sync2 && i_if) begin
               w_nextState = ACK1;
               w_nextInta  = 1'b0;
               w_nextCnt   = LOW_LOAD;
            end
         end
         ACK1: begin
            if (w_cntZero) begin
               w_nextState = GAP;
               w_nextInta  = 1'b1;
               w_nextCnt   = GAP_LOAD;
            end else begin
               w_nextCnt = r_cnt - CW'(1);
            end
         end
         GAP: begin
            if (w_cntZero) begin
               w_nextState = ACK2;
               w_nextInta  = 1'b0;
               w_nextCnt   = LOW_LOAD;
               w_nextCap   = 1'b0;
            end else begin
               w_nextCnt = r_cnt - CW'(1);
            end
         end
         ACK2: begin
            // Only the first strobe of pulse 2 is kept; a strobe on the exit cycle still counts.
            if (i_iv_ready && !r_cap) begin
               w_nextVec = i_data_in;
               w_nextCap = 1'b1;
            end
            if (w_cntZero) begin
               w_nextInta = 1'b1;
               if (r_cap || i_iv_ready) begin
                  w_nextState = HOLD;
                  w_nextValid = 1'b1;
               end else begin
                  w_nextTimeout = 1'b1;
                  w_nextState   = (RECOVER_CYC > 0) ? RECOVER : IDLE;
                  w_nextCnt     = REC_LOAD;
               end
            end else begin
               w_nextCnt = r_cnt - CW'(1);
            end
         end
         HOLD: begin
            if (i_vec_ack) begin
               w_nextValid = 1'b0;
               w_nextState = (RECOVER_CYC > 0) ? RECOVER : IDLE;
               w_nextCnt   = REC_LOAD;
            end
         end
         RECOVER: begin
            if (w_cntZero) begin
               w_nextState = IDLE;
            end else begin
               w_nextCnt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextInta  = 1'b1;
         end
      endcase
   end

   assign o_inta        = r_inta;
   assign o_vec         = r_vec;
   assign o_vec_valid   = r_vecValid;
   assign o_busy        = (r_state != IDLE);
   assign o_timeout_err = r_timeout;

endmodule
